// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if: one requester's connection to the SRAM arbiter.
//
// Signals:
//   req    requester -> arbiter  access request, held until gnt
//   we     requester -> arbiter  1 = write, 0 = read
//   lock   requester -> arbiter  ask to keep ownership next cycle (burst)
//   addr   requester -> arbiter  access address (AW bits)
//   wdata  requester -> arbiter  write data (BW bits)
//   gnt    arbiter -> requester  access accepted this cycle (combinational)
//   rvalid arbiter -> requester  read data valid, one cycle after a read grant
//   rdata  arbiter -> requester  read data, 0 when rvalid is 0
//
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int unsigned BW = 32,
    parameter int unsigned AW = 10
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [BW-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter: two-requester round-robin arbiter sharing one single-port
// synchronous SRAM (1-cycle registered read). At most one SRAM access per
// cycle. A granted port may hold ownership for a bounded locked burst of up
// to MAXBURST consecutive grants. Read data is routed back to the requester
// that issued the read, one cycle after its grant.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rstn       synchronous active-low reset
//   port0/1    requester interfaces (sram_arbiter_if.slave)
//   sram_csn   SRAM chip select, active-low
//   sram_wen   SRAM write enable, 1 = read, 0 = write
//   sram_a     SRAM address
//   sram_di    SRAM write data
//   sram_dout  SRAM read data (valid the cycle after a read access)
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int unsigned BW       = 32,
    parameter int unsigned AW       = 10,
    parameter int unsigned MAXBURST = 4
) (
    input  logic          clk,
    input  logic          rstn,
    sram_arbiter_if.slave port0,
    sram_arbiter_if.slave port1,
    output logic          sram_csn,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [BW-1:0] sram_di,
    input  logic [BW-1:0] sram_dout
);

    // Ownership states
    localparam logic [1:0] StOpen  = 2'd0;
    localparam logic [1:0] StLock0 = 2'd1;
    localparam logic [1:0] StLock1 = 2'd2;

    // bcnt counts grants already taken in the current burst (1..MAXBURST-1)
    localparam int unsigned BcntW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [BcntW-1:0] BcntLast = BcntW'(MAXBURST - 1);

    logic [1:0]       state_q, state_d;
    logic             pri_q, pri_d;
    logic [BcntW-1:0] bcnt_q, bcnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_port_q, rd_port_d;

    logic             gnt_valid;
    logic             gnt_idx;
    logic             owner_hold;

    logic             sel_we;
    logic             sel_lock;
    logic [AW-1:0]    sel_addr;
    logic [BW-1:0]    sel_wdata;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_idx    = 1'b0;
        owner_hold = 1'b0;
        if (rstn) begin
            if (state_q == StLock0 && port0.req) begin
                gnt_valid  = 1'b1;
                gnt_idx    = 1'b0;
                owner_hold = 1'b1;
            end else if (state_q == StLock1 && port1.req) begin
                gnt_valid  = 1'b1;
                gnt_idx    = 1'b1;
                owner_hold = 1'b1;
            end else if (port0.req && port1.req) begin
                // Lock owner absent or no lock: plain round-robin tie-break
                gnt_valid = 1'b1;
                gnt_idx   = pri_q;
            end else if (port0.req) begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b0;
            end else if (port1.req) begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b1;
            end
        end
    end

    assign sel_we    = gnt_idx ? port1.we    : port0.we;
    assign sel_lock  = gnt_idx ? port1.lock  : port0.lock;
    assign sel_addr  = gnt_idx ? port1.addr  : port0.addr;
    assign sel_wdata = gnt_idx ? port1.wdata : port0.wdata;

    assign port0.gnt = gnt_valid && !gnt_idx;
    assign port1.gnt = gnt_valid &&  gnt_idx;

    // ------------------------------------------------------------------
    // SRAM command
    // ------------------------------------------------------------------
    always_comb begin
        sram_csn = 1'b1;
        sram_wen = 1'b0;
        sram_a   = '0;
        sram_di  = '0;
        if (!rstn) begin
            // Held inactive during reset: WEN parks at read
            sram_wen = 1'b1;
        end else if (gnt_valid) begin
            sram_csn = 1'b0;
            sram_wen = ~sel_we;
            sram_a   = sel_addr;
            sram_di  = sel_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: priority, burst lock and pending read
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        pri_d     = pri_q;
        rd_pend_d = 1'b0;
        rd_port_d = rd_port_q;

        if (gnt_valid) begin
            pri_d     = ~gnt_idx;
            rd_pend_d = ~sel_we;
            rd_port_d = gnt_idx;

            if (owner_hold) begin
                // Continue burst only while below the length bound
                if (sel_lock && (bcnt_q < BcntLast)) begin
                    bcnt_d = bcnt_q + BcntW'(1);
                end else begin
                    state_d = StOpen;
                    bcnt_d  = '0;
                end
            end else if (sel_lock && (MAXBURST > 1)) begin
                // Grant taken from open arbitration (incl. absent lock owner)
                state_d = gnt_idx ? StLock1 : StLock0;
                bcnt_d  = BcntW'(1);
            end else begin
                state_d = StOpen;
                bcnt_d  = '0;
            end
        end else begin
            // No grant: any lock owner has stopped requesting
            state_d = StOpen;
            bcnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StOpen;
            pri_q     <= 1'b0;
            bcnt_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pri_q     <= pri_d;
            bcnt_q    <= bcnt_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    // ------------------------------------------------------------------
    // Read return. Gated by rstn so a read pending when reset arrives is
    // never delivered, even in the first reset cycle.
    // ------------------------------------------------------------------
    logic rvalid0, rvalid1;

    assign rvalid0 = rstn && rd_pend_q && !rd_port_q;
    assign rvalid1 = rstn && rd_pend_q &&  rd_port_q;

    assign port0.rvalid = rvalid0;
    assign port1.rvalid = rvalid1;
    assign port0.rdata  = rvalid0 ? sram_dout : '0;
    assign port1.rdata  = rvalid1 ? sram_dout : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter: self-checking bench for sram_arbiter. A behavioural SRAM
// sits on the SRAM side; a reference model (priority pointer, burst owner and
// length, pending read, shadow memory) predicts every output each cycle.
// Directed scenarios add literal expectations; a random phase follows.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;
    localparam int unsigned BW   = 32;
    localparam int unsigned AW   = 10;
    localparam int unsigned MAXB = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if #(.BW(BW), .AW(AW)) if0 ();
    sram_arbiter_if #(.BW(BW), .AW(AW)) if1 ();

    logic          sram_csn;
    logic          sram_wen;
    logic [AW-1:0] sram_a;
    logic [BW-1:0] sram_di;
    logic [BW-1:0] sram_dout;

    sram_arbiter #(.BW(BW), .AW(AW), .MAXBURST(MAXB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .port0     (if0),
        .port1     (if1),
        .sram_csn  (sram_csn),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_di   (sram_di),
        .sram_dout (sram_dout)
    );

    // Behavioural single-port SRAM, registered read
    logic [BW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (!sram_csn) begin
            if (!sram_wen) mem[sram_a] <= sram_di;
            else           sram_dout   <= mem[sram_a];
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model
    int            m_pri      = 0;
    int            m_run_port = -1;
    int            m_run_len  = 0;
    int            m_rd_port  = -1;
    logic [BW-1:0] m_rd_data  = '0;
    logic [BW-1:0] exp_mem [0:1023];
    int            c_eg       = -1;

    // Outputs captured in the last step
    logic [1:0]    a_gnt, a_rv;
    logic          a_csn, a_wen;
    logic [AW-1:0] a_a;
    logic [BW-1:0] a_di, a_rd0, a_rd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] a, input logic [BW-1:0] d);
        if (p == 0) begin
            if0.req = req; if0.we = we; if0.lock = lock; if0.addr = a; if0.wdata = d;
        end else begin
            if1.req = req; if1.we = we; if1.lock = lock; if1.addr = a; if1.wdata = d;
        end
    endtask

    // One clock: predict and compare at negedge, advance model at posedge
    task automatic step();
        int            eg, lockp, taken;
        logic          r0, r1, g_we, g_lock;
        logic [AW-1:0] g_a;
        logic [BW-1:0] g_d;
        logic [1:0]    e_gnt, e_rv;
        logic          e_csn, e_wen;
        logic [AW-1:0] e_a;
        logic [BW-1:0] e_di, e_rd0, e_rd1;

        @(negedge clk);
        r0 = if0.req;
        r1 = if1.req;
        eg = -1;
        lockp = -1;
        if (rstn) begin
            if (m_run_port == 0 && r0) lockp = 0;
            if (m_run_port == 1 && r1) lockp = 1;
            if (lockp >= 0)      eg = lockp;
            else if (r0 && r1)   eg = m_pri;
            else if (r0)         eg = 0;
            else if (r1)         eg = 1;
        end
        g_we   = (eg == 1) ? if1.we    : if0.we;
        g_lock = (eg == 1) ? if1.lock  : if0.lock;
        g_a    = (eg == 1) ? if1.addr  : if0.addr;
        g_d    = (eg == 1) ? if1.wdata : if0.wdata;

        e_gnt = (eg == 0) ? 2'b01 : (eg == 1) ? 2'b10 : 2'b00;
        e_csn = (eg < 0);
        e_wen = !rstn ? 1'b1 : (eg < 0) ? 1'b0 : ~g_we;
        e_a   = (eg < 0) ? '0 : g_a;
        e_di  = (eg < 0) ? '0 : g_d;
        e_rv  = !rstn ? 2'b00 : (m_rd_port == 0) ? 2'b01 : (m_rd_port == 1) ? 2'b10 : 2'b00;
        e_rd0 = e_rv[0] ? m_rd_data : '0;
        e_rd1 = e_rv[1] ? m_rd_data : '0;

        a_gnt = {if1.gnt, if0.gnt};
        a_rv  = {if1.rvalid, if0.rvalid};
        a_csn = sram_csn;
        a_wen = sram_wen;
        a_a   = sram_a;
        a_di  = sram_di;
        a_rd0 = if0.rdata;
        a_rd1 = if1.rdata;

        chk("gnt",      a_gnt, e_gnt);
        chk("sram_csn", a_csn, e_csn);
        chk("sram_wen", a_wen, e_wen);
        chk("sram_a",   a_a,   e_a);
        chk("sram_di",  a_di,  e_di);
        chk("rvalid",   a_rv,  e_rv);
        chk("rdata0",   a_rd0, e_rd0);
        chk("rdata1",   a_rd1, e_rd1);
        c_eg = eg;

        @(posedge clk);
        if (!rstn) begin
            m_pri = 0; m_run_port = -1; m_run_len = 0; m_rd_port = -1;
        end else if (eg < 0) begin
            m_run_port = -1; m_run_len = 0; m_rd_port = -1;
        end else begin
            m_pri = 1 - eg;
            if (lockp == eg) begin
                taken = m_run_len + 1;
                if (g_lock && taken < int'(MAXB)) m_run_len = taken;
                else begin m_run_port = -1; m_run_len = 0; end
            end else if (g_lock && MAXB > 1) begin
                m_run_port = eg; m_run_len = 1;
            end else begin
                m_run_port = -1; m_run_len = 0;
            end
            if (g_we) begin
                exp_mem[g_a] = g_d;
                m_rd_port    = -1;
            end else begin
                m_rd_port = eg;
                m_rd_data = exp_mem[g_a];
            end
        end
        #1;
    endtask

    initial begin
        logic cur_req;

        drive(0, 1'b1, 1'b0, 1'b0, 10'd1, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 10'd2, '0);
        rstn = 1'b0;

        // Reset holds everything inactive despite requests
        step();
        chk("rst_gnt", a_gnt, 2'b00);
        chk("rst_csn", a_csn, 1'b1);
        step();
        chk("rst_rvalid", a_rv, 2'b00);

        // Fill addresses 0..15 through port 0
        rstn = 1'b1;
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0, AW'(i), (i == 5) ? 32'hDEADBEEF : $urandom);
            step();
            chk("init_gnt", a_gnt, 2'b01);
        end

        // Round-robin from reset
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 10'd1, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 10'd2, '0);
        for (int i = 0; i < 7; i++) begin
            step();
            if (i < 6) chk("rr_gnt", a_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) chk("rr_rvalid", a_rv, (i % 2 == 1) ? 2'b01 : 2'b10);
        end
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        // Single read
        drive(0, 1'b1, 1'b0, 1'b0, 10'd5, '0);
        step();
        chk("rd_gnt", a_gnt, 2'b01);
        chk("rd_addr", a_a, 10'd5);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        chk("rd_rvalid", a_rv, 2'b01);
        chk("rd_data", a_rd0, 32'hDEADBEEF);

        // Bounded lock: port 1 keeps MAXBURST grants, then port 0
        drive(1, 1'b1, 1'b0, 1'b1, 10'd7, '0);
        step();
        chk("lock_t0", a_gnt, 2'b10);
        drive(0, 1'b1, 1'b0, 1'b0, 10'd8, '0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("lock_hold", a_gnt, 2'b10);
        end
        step();
        chk("lock_release", a_gnt, 2'b01);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        // Lock dropped after one extra grant
        drive(1, 1'b1, 1'b0, 1'b1, 10'd7, '0);
        step();
        chk("unlock_t0", a_gnt, 2'b10);
        drive(0, 1'b1, 1'b0, 1'b0, 10'd8, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 10'd7, '0);
        step();
        chk("unlock_t1", a_gnt, 2'b10);
        step();
        chk("unlock_t2", a_gnt, 2'b01);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        // Write then read of same address on the other port
        drive(0, 1'b1, 1'b1, 1'b0, 10'd3, 32'h12345678);
        step();
        chk("wr_gnt", a_gnt, 2'b01);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 10'd3, '0);
        step();
        chk("wr_rd_gnt", a_gnt, 2'b10);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        chk("wr_rd_rvalid", a_rv, 2'b10);
        chk("wr_rd_data", a_rd1, 32'h12345678);

        // Reset arriving while a read is pending
        drive(0, 1'b1, 1'b0, 1'b0, 10'd5, '0);
        step();
        chk("midrst_gnt", a_gnt, 2'b01);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        rstn = 1'b0;
        step();
        chk("midrst_rv1", a_rv, 2'b00);
        step();
        chk("midrst_rv2", a_rv, 2'b00);
        rstn = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 10'd1, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 10'd2, '0);
        step();
        chk("midrst_tie", a_gnt, 2'b01);

        // Random traffic, requests held until granted
        for (int n = 0; n < 3000; n++) begin
            rstn = ($urandom_range(0, 149) != 0);
            for (int p = 0; p < 2; p++) begin
                cur_req = (p == 0) ? if0.req : if1.req;
                if (!cur_req || c_eg == p) begin
                    drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
                end
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
